// File: rtl/filter_pkg.sv
// Shared constants and state encoding for the layer-controller address sequencers.
package filter_pkg;
  localparam int TAPS        = 9;
  localparam int MAX_FILTERS = 16;
  localparam int ADDR_W      = 8;
  localparam int TAP_W       = 4;
  localparam int FIL_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;
endpackage

// File: rtl/filter_addr_sequencer_tap_counter.sv
// Modulo-TAPS tap counter; clear beats enable, wrap flags the terminal count being consumed.
// Count updates the cycle after en; wrap is combinational from en and the registered count.
module tap_counter
  import filter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_n,
  input  logic             en,
  output logic [TAP_W-1:0] cnt,
  output logic             wrap
);

  logic [TAP_W-1:0] cnt_q, cnt_d;
  logic             at_end;

  always_comb begin
    at_end = (cnt_q == TAP_W'(TAPS - 1));
    cnt_d  = cnt_q;
    if (!clr_n) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_end ? '0 : cnt_q + TAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = en & at_end;

endmodule

// File: rtl/filter_addr_sequencer.sv
// Walks filters x taps of the weight buffer, one address per valid/ready transfer.
// First address one cycle after start; all outputs are registered and hold while addr_ready is low.
module filter_addr_sequencer
  import filter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [FIL_W-1:0]  cfg_filters,
  input  logic [ADDR_W-1:0] cfg_base,
  output logic [ADDR_W-1:0] addr_out,
  output logic [TAP_W-1:0]  tap_idx,
  output logic [FIL_W-1:0]  filter_idx,
  output logic              last_tap,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              busy,
  output logic              done
);

  seq_state_e        state_q, state_d;
  logic [FIL_W-1:0]  filters_q, filters_d;
  logic [FIL_W-1:0]  filter_q, filter_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TAP_W-1:0]  tap;
  logic              xfer, tap_wrap, tap_clr_n;

  // abort suppresses the transfer so the final beat cannot sneak a done through
  assign xfer      = (state_q == ST_RUN) & addr_ready & ~abort;
  assign tap_clr_n = ~(abort & (state_q != ST_IDLE));

  tap_counter u_tap_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_n (tap_clr_n),
    .en    (xfer),
    .cnt   (tap),
    .wrap  (tap_wrap)
  );

  always_comb begin
    state_d   = state_q;
    filters_d = filters_q;
    filter_d  = filter_q;
    addr_d    = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          filters_d = cfg_filters;
          filter_d  = '0;
          if (cfg_filters == '0 || cfg_filters > FIL_W'(MAX_FILTERS)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            addr_d  = cfg_base;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d  = ST_IDLE;
          filter_d = '0;
          addr_d   = '0;
        end else if (xfer) begin
          if (tap_wrap && filter_q == filters_q - FIL_W'(1)) begin
            state_d  = ST_DONE;
            filter_d = '0;
            addr_d   = '0;
          end else begin
            // address stays contiguous across filters, so a plain increment suffices
            addr_d = addr_q + ADDR_W'(1);
            if (tap_wrap) begin
              filter_d = filter_q + FIL_W'(1);
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      filters_q <= '0;
      filter_q  <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      filters_q <= filters_d;
      filter_q  <= filter_d;
      addr_q    <= addr_d;
    end
  end

  assign addr_out   = addr_q;
  assign tap_idx    = tap;
  assign filter_idx = filter_q;
  assign addr_valid = (state_q == ST_RUN);
  assign last_tap   = addr_valid & (tap == TAP_W'(TAPS - 1));
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_filter_addr_sequencer.sv
// Randomized bench: expected address stream is (base + k) mod 256 for transfer k of filters*9.
module tb_filter_addr_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [4:0] cfg_filters;
  logic [7:0] cfg_base;
  logic [7:0] addr_out;
  logic [3:0] tap_idx;
  logic [4:0] filter_idx;
  logic       last_tap;
  logic       addr_valid;
  logic       addr_ready;
  logic       busy;
  logic       done;

  int n_chk = 0;
  int n_err = 0;

  filter_addr_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cfg_filters (cfg_filters),
    .cfg_base    (cfg_base),
    .addr_out    (addr_out),
    .tap_idx     (tap_idx),
    .filter_idx  (filter_idx),
    .last_tap    (last_tap),
    .addr_valid  (addr_valid),
    .addr_ready  (addr_ready),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_valid"}, addr_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_addr"}, addr_out, 0);
    check_eq({tag, "_tap"}, tap_idx, 0);
    check_eq({tag, "_filter"}, filter_idx, 0);
    check_eq({tag, "_last"}, last_tap, 0);
  endtask

  // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0 repeating
  task automatic run_layer(input int nf, input int base, input int mode,
                           input int abort_k, input bit junk_start);
    int total, k, cyc;
    bit rdy, ab, aborted;
    cfg_filters = 5'(nf);
    cfg_base    = 8'(base);
    start       = 1'b1;
    step();
    start       = 1'b0;
    cfg_filters = 5'($urandom_range(0, 31));
    cfg_base    = 8'($urandom_range(0, 255));
    if (nf == 0 || nf > 16) begin
      check_eq("bad_cfg_valid", addr_valid, 0);
      check_eq("bad_cfg_done", done, 1);
      check_eq("bad_cfg_busy", busy, 1);
      step();
      check_eq("bad_cfg_done_after", done, 0);
      check_eq("bad_cfg_busy_after", busy, 0);
      return;
    end
    total   = nf * 9;
    k       = 0;
    cyc     = 0;
    aborted = 1'b0;
    while (k < total && !aborted && cyc < 4000) begin
      check_eq("run_valid", addr_valid, 1);
      check_eq("run_addr", addr_out, (base + k) % 256);
      check_eq("run_tap", tap_idx, k % 9);
      check_eq("run_filter", filter_idx, k / 9);
      check_eq("run_last", last_tap, (k % 9 == 8) ? 1 : 0);
      check_eq("run_done", done, 0);
      check_eq("run_busy", busy, 1);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc % 3 == 0);
      endcase
      ab = (k == abort_k);
      if (ab) rdy = 1'b1;
      addr_ready = rdy;
      abort      = ab;
      start      = junk_start ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      cyc++;
      addr_ready = 1'b0;
      abort      = 1'b0;
      start      = 1'b0;
      if (rdy) k++;
      if (ab) aborted = 1'b1;
    end
    if (aborted) begin
      check_eq("abort_valid", addr_valid, 0);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_done", done, 0);
      step();
      check_eq("abort_done_late", done, 0);
      return;
    end
    check_eq("xfer_count", k, total);
    check_eq("end_valid", addr_valid, 0);
    check_eq("end_done", done, 1);
    check_eq("end_busy", busy, 1);
    check_eq("end_addr", addr_out, 0);
    check_eq("end_tap", tap_idx, 0);
    check_eq("end_filter", filter_idx, 0);
    step();
    check_eq("post_done", done, 0);
    check_eq("post_busy", busy, 0);
    check_eq("post_valid", addr_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    addr_ready  = 1'b0;
    cfg_filters = '0;
    cfg_base    = '0;
    step();
    check_idle_zero("reset0");
    step();
    check_idle_zero("reset1");
    rst = 1'b1;
    step();

    run_layer(2, 0, 0, -1, 0);
    run_layer(1, 0, 2, -1, 0);
    run_layer(0, 33, 0, -1, 0);
    run_layer(17, 33, 0, -1, 0);
    run_layer(1, 250, 0, -1, 0);
    run_layer(2, 0, 1, 13, 0);
    run_layer(2, 0, 0, -1, 0);

    // reset in the middle of a run
    cfg_filters = 5'd3;
    cfg_base    = 8'd5;
    start       = 1'b1;
    step();
    start      = 1'b0;
    addr_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check_idle_zero("rst_mid");
    rst        = 1'b1;
    addr_ready = 1'b0;
    step();
    check_idle_zero("rst_after");

    // start together with abort in IDLE is ignored, abort alone does nothing
    cfg_filters = 5'd2;
    start       = 1'b1;
    abort       = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_idle_zero("start_abort");
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle_zero("abort_idle");

    run_layer(3, 100, 1, -1, 1);
    run_layer(2, 7, 0, 17, 0);
    run_layer(2, 7, 2, -1, 0);
    run_layer(16, 240, 1, -1, 1);

    for (int i = 0; i < 12; i++) begin
      int nf, ak;
      nf = $urandom_range(0, 18);
      ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nf * 9)) : -1;
      run_layer(nf, $urandom_range(0, 255), $urandom_range(0, 2), ak, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
